// File: rtl/sonar_if.sv
// Sensor-side and result-side signals of the sonar sequencer.
// master = the sequencer, slave = sensor pins plus result consumer.
interface sonar_if #(
  parameter int unsigned N_SENSORS = 4
);
  logic                 enable;
  logic [N_SENSORS-1:0] echo;
  logic [N_SENSORS-1:0] trig;
  logic [9:0]           dist_cm;
  logic [1:0]           dist_id;
  logic                 dist_valid;
  logic                 dist_timeout;
  logic [N_SENSORS-1:0] near;
  logic                 busy;

  modport master (
    input  enable, echo,
    output trig, dist_cm, dist_id, dist_valid, dist_timeout, near, busy
  );

  modport slave (
    output enable, echo,
    input  trig, dist_cm, dist_id, dist_valid, dist_timeout, near, busy
  );
endinterface

// File: rtl/sonar_sequencer.sv
// Round-robin HC-SR04 scheduler: trigger, time the echo in us, divide by 58
// and publish one tagged distance per sensor slot.
module sonar_sequencer #(
  parameter int unsigned N_SENSORS       = 4,
  parameter int unsigned CLKS_PER_US     = 50,
  parameter int unsigned TRIG_US         = 10,
  parameter int unsigned ECHO_TIMEOUT_US = 30000,
  parameter int unsigned SLOT_US         = 40000,
  parameter int unsigned NEAR_CM         = 5
) (
  input  logic     clock,
  input  logic     reset_n,
  sonar_if.master  bus
);

  localparam int unsigned PRE_W  = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int unsigned US_W   = 15;
  localparam int unsigned SLOT_W = 16;
  localparam int unsigned CM_W   = 10;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLKS_PER_US - 1);
  localparam logic [US_W-1:0]   TRIG_LAST = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]   TO_LAST   = US_W'(ECHO_TIMEOUT_US - 1);
  localparam logic [US_W-1:0]   DIVISOR   = US_W'(58);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_US - 1);
  localparam logic [SLOT_W-1:0] SLOT_END  = SLOT_W'(SLOT_US);
  localparam logic [CM_W-1:0]   CM_MAX    = '1;
  localparam logic [CM_W-1:0]   NEAR_LIM  = CM_W'(NEAR_CM);
  localparam logic [1:0]        SEL_LAST  = 2'(N_SENSORS - 1);

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT_RISE, MEASURE, DIVIDE, PUBLISH, GUARD
  } state_t;

  state_t               state;
  logic [1:0]           sel;
  logic [US_W-1:0]      us_cnt;
  logic [US_W-1:0]      rem;
  logic [CM_W-1:0]      quo;
  logic [PRE_W-1:0]     pre_cnt;
  logic [SLOT_W-1:0]    slot_cnt;
  logic [N_SENSORS-1:0] echo_m, echo_s, echo_d;

  logic [N_SENSORS-1:0] trig_q, near_q;
  logic [CM_W-1:0]      dist_cm_q;
  logic [1:0]           dist_id_q;
  logic                 dist_valid_q, dist_timeout_q, busy_q;

  logic                 us_tick, echo_cur, echo_rise, slot_done, enter_trig;
  logic                 pub_go, pub_to, pub_near;
  logic [CM_W-1:0]      pub_cm;
  logic [1:0]           sel_next;
  logic [N_SENSORS-1:0] sel_mask, next_mask;
  logic [3:0]           echo_s_w, echo_d_w;

  assign bus.trig         = trig_q;
  assign bus.dist_cm      = dist_cm_q;
  assign bus.dist_id      = dist_id_q;
  assign bus.dist_valid   = dist_valid_q;
  assign bus.dist_timeout = dist_timeout_q;
  assign bus.near         = near_q;
  assign bus.busy         = busy_q;

  // Two-flop synchronizer plus one delay stage for rise detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_d <= '0;
    end else begin
      echo_m <= bus.echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  always_comb begin
    us_tick    = (pre_cnt == PRE_LAST);
    echo_s_w   = 4'(echo_s);
    echo_d_w   = 4'(echo_d);
    echo_cur   = echo_s_w[sel];
    echo_rise  = echo_cur & ~echo_d_w[sel];
    sel_next   = (sel == SEL_LAST) ? 2'd0 : sel + 2'd1;
    sel_mask   = N_SENSORS'(1) << sel;
    next_mask  = N_SENSORS'(1) << sel_next;
    // The tick that carries the timer to SLOT_US ends the slot on that edge
    slot_done  = (slot_cnt >= SLOT_END) || (us_tick && slot_cnt == SLOT_LAST);
    enter_trig = bus.enable && ((state == IDLE) || (state == GUARD && slot_done));
    pub_go     = 1'b0;
    pub_to     = 1'b0;
    case (state)
      WAIT_RISE: if (!echo_rise && us_tick && us_cnt == TO_LAST) begin
        pub_go = 1'b1;
        pub_to = 1'b1;
      end
      MEASURE: if (echo_cur && us_tick && us_cnt == TO_LAST) begin
        pub_go = 1'b1;
        pub_to = 1'b1;
      end
      DIVIDE: if (rem < DIVISOR) pub_go = 1'b1;
      default: ;
    endcase
    pub_cm   = pub_to ? CM_MAX : quo;
    pub_near = !pub_to && (pub_cm <= NEAR_LIM);
  end

  // us prescaler and slot timer, both restarted on TRIG entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt  <= '0;
      slot_cnt <= '0;
    end else if (enter_trig) begin
      pre_cnt  <= '0;
      slot_cnt <= '0;
    end else if (us_tick) begin
      pre_cnt  <= '0;
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end else begin
      pre_cnt  <= pre_cnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      sel            <= '0;
      us_cnt         <= '0;
      rem            <= '0;
      quo            <= '0;
      trig_q         <= '0;
      near_q         <= '0;
      dist_cm_q      <= '0;
      dist_id_q      <= '0;
      dist_valid_q   <= 1'b0;
      dist_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      dist_valid_q <= 1'b0;
      if (pub_go) begin
        state          <= PUBLISH;
        dist_cm_q      <= pub_cm;
        dist_id_q      <= sel;
        dist_timeout_q <= pub_to;
        dist_valid_q   <= 1'b1;
        near_q         <= pub_near ? (near_q | sel_mask) : (near_q & ~sel_mask);
      end
      case (state)
        IDLE: if (bus.enable) begin
          state  <= TRIG;
          sel    <= '0;
          us_cnt <= '0;
          trig_q <= N_SENSORS'(1);
          busy_q <= 1'b1;
        end
        TRIG: if (us_tick) begin
          if (us_cnt == TRIG_LAST) begin
            state  <= WAIT_RISE;
            trig_q <= '0;
            us_cnt <= '0;
          end else begin
            us_cnt <= us_cnt + US_W'(1);
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            // A tick coinciding with the rise belongs to the echo window
            state  <= MEASURE;
            us_cnt <= us_tick ? US_W'(1) : '0;
          end else if (!pub_go && us_tick) begin
            us_cnt <= us_cnt + US_W'(1);
          end
        end
        MEASURE: begin
          if (!echo_cur) begin
            state <= DIVIDE;
            rem   <= us_cnt;
            quo   <= '0;
          end else if (!pub_go && us_tick) begin
            us_cnt <= us_cnt + US_W'(1);
          end
        end
        DIVIDE: if (!pub_go) begin
          rem <= rem - DIVISOR;
          quo <= (quo == CM_MAX) ? quo : quo + CM_W'(1);
        end
        PUBLISH: state <= GUARD;
        GUARD: if (slot_done) begin
          if (bus.enable) begin
            state  <= TRIG;
            sel    <= sel_next;
            us_cnt <= '0;
            trig_q <= next_mask;
          end else begin
            state  <= IDLE;
            sel    <= '0;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_sequencer.sv
// Directed bench for sonar_sequencer with shortened timing (4 clk/us, 2000 us slots).
module tb_sonar_sequencer;

  localparam int CPU   = 4;
  localparam int SLOT  = 2000 * CPU;
  localparam int TO_CY = 900 * CPU;

  logic clock;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   vcnt;
  bit   multi_trig;

  sonar_if #(.N_SENSORS(4)) bus ();

  sonar_sequencer #(
    .N_SENSORS(4), .CLKS_PER_US(4), .TRIG_US(10),
    .ECHO_TIMEOUT_US(900), .SLOT_US(2000), .NEAR_CM(5)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.dist_valid === 1'b1) vcnt <= vcnt + 1;
    if ($countones(bus.trig) > 1) multi_trig <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full slot: wait trigger, optionally drive an echo, check the published result
  task automatic run_slot(input int s, input int width_us, input bit drop_en,
                          input int exp_cm, input bit exp_to, input logic [3:0] exp_near,
                          output int rise);
    int n;
    int hl;
    logic [3:0] oh;
    oh = 4'b0001 << s;
    n = 0;
    while (bus.trig === 4'b0000 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    rise = cyc;
    check($sformatf("slot%0d_trig_onehot", s), 32'(bus.trig), 32'(oh));
    hl = 0;
    do begin
      hl++;
      @(negedge clock);
    end while (bus.trig[s] === 1'b1 && hl < 1000);
    check($sformatf("slot%0d_trig_cycles", s), 32'(hl), 32'(10 * CPU));
    n = 0;
    if (exp_to) begin
      while (bus.dist_valid !== 1'b1 && n < 5000) begin
        @(negedge clock);
        n++;
      end
      check($sformatf("slot%0d_timeout_latency", s), 32'(n), 32'(TO_CY));
    end else begin
      repeat (100 * CPU) @(negedge clock);
      bus.echo[s] = 1'b1;
      repeat (width_us * CPU / 2) @(negedge clock);
      if (drop_en) bus.enable = 1'b0;
      repeat (width_us * CPU - width_us * CPU / 2) @(negedge clock);
      bus.echo[s] = 1'b0;
      do begin
        @(negedge clock);
        n++;
      end while (bus.dist_valid !== 1'b1 && n < 5000);
      check($sformatf("slot%0d_fall_to_valid", s), 32'(n), 32'(exp_cm + 4));
    end
    check($sformatf("slot%0d_valid", s), 32'(bus.dist_valid), 32'd1);
    check($sformatf("slot%0d_dist_cm", s), 32'(bus.dist_cm), 32'(exp_cm));
    check($sformatf("slot%0d_dist_id", s), 32'(bus.dist_id), 32'(s));
    check($sformatf("slot%0d_timeout", s), 32'(bus.dist_timeout), 32'(exp_to));
    check($sformatf("slot%0d_near", s), 32'(bus.near), 32'(exp_near));
    @(negedge clock);
    check($sformatf("slot%0d_valid_drop", s), 32'(bus.dist_valid), 32'd0);
    check($sformatf("slot%0d_cm_hold", s), 32'(bus.dist_cm), 32'(exp_cm));
  endtask

  initial begin
    int r0, r1, r2, r3, r4, r5, r6;
    int n;
    int vsnap;
    n_cmp      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    bus.enable = 1'b0;
    bus.echo   = 4'b0000;
    repeat (3) @(negedge clock);
    check("rst_trig", 32'(bus.trig), 32'd0);
    check("rst_dist_cm", 32'(bus.dist_cm), 32'd0);
    check("rst_dist_id", 32'(bus.dist_id), 32'd0);
    check("rst_valid", 32'(bus.dist_valid), 32'd0);
    check("rst_timeout", 32'(bus.dist_timeout), 32'd0);
    check("rst_near", 32'(bus.near), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_trig", 32'(bus.trig), 32'd0);
    bus.enable = 1'b1;

    run_slot(0, 580, 1'b0, 10, 1'b0, 4'b0000, r0);
    check("busy_running", 32'(bus.busy), 32'd1);
    run_slot(1, 290, 1'b0, 5, 1'b0, 4'b0010, r1);
    check("period_0_1", 32'(r1 - r0), 32'(SLOT));
    run_slot(2, 0, 1'b0, 1023, 1'b1, 4'b0010, r2);
    check("period_1_2", 32'(r2 - r1), 32'(SLOT));
    bus.echo[3] = 1'b1;
    run_slot(3, 0, 1'b0, 1023, 1'b1, 4'b0010, r3);
    bus.echo[3] = 1'b0;
    check("period_2_3", 32'(r3 - r2), 32'(SLOT));
    run_slot(0, 347, 1'b0, 5, 1'b0, 4'b0011, r4);
    check("period_3_0", 32'(r4 - r3), 32'(SLOT));
    run_slot(1, 348, 1'b0, 6, 1'b0, 4'b0001, r5);
    check("period_0_1b", 32'(r5 - r4), 32'(SLOT));

    run_slot(2, 116, 1'b1, 2, 1'b0, 4'b0101, r6);
    check("period_1_2b", 32'(r6 - r5), 32'(SLOT));
    n = 0;
    while (bus.busy !== 1'b0 && n < 10000) begin
      @(negedge clock);
      n++;
    end
    check("disable_slot_end", 32'(cyc - r6), 32'(SLOT));
    repeat (100) @(negedge clock);
    check("disabled_trig", 32'(bus.trig), 32'd0);
    check("disabled_busy", 32'(bus.busy), 32'd0);
    check("no_trig_overlap", 32'(multi_trig), 32'd0);

    bus.enable = 1'b1;
    n = 0;
    while (bus.trig === 4'b0000 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("reenable_trig0", 32'(bus.trig), 32'd1);
    n = 0;
    while (bus.trig !== 4'b0000 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    repeat (100 * CPU) @(negedge clock);
    bus.echo[0] = 1'b1;
    repeat (800 * CPU) @(negedge clock);
    bus.echo[0] = 1'b0;
    repeat (8) @(negedge clock);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    check("pre_reset_no_valid", 32'(bus.dist_valid), 32'd0);
    vsnap = vcnt;
    reset_n = 1'b0;
    #1;
    check("mid_rst_trig", 32'(bus.trig), 32'd0);
    check("mid_rst_dist_cm", 32'(bus.dist_cm), 32'd0);
    check("mid_rst_dist_id", 32'(bus.dist_id), 32'd0);
    check("mid_rst_valid", 32'(bus.dist_valid), 32'd0);
    check("mid_rst_timeout", 32'(bus.dist_timeout), 32'd0);
    check("mid_rst_near", 32'(bus.near), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    bus.enable = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (200) @(negedge clock);
    check("post_rst_no_strobe", 32'(vcnt - vsnap), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_cm", 32'(bus.dist_cm), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
